// File: rtl/mul_div_unit_pkg.sv
// mul_div_unit_pkg
//   Shared definitions for the HI/LO multiply/divide unit of the MIPS core.
//   funct_t     : R-type funct field values that the unit or the decoder cares
//                 about (MFHI/MFLO are decoded elsewhere and read hi/lo directly).
//   mdu_state_t : iterative engine states IDLE -> CALC -> FIXUP -> IDLE.
//   Helper functions classify a funct code as iterative and/or signed.
package mul_div_unit_pkg;

  typedef enum logic [5:0] {
    FUNCT_MFHI  = 6'h10,
    FUNCT_MTHI  = 6'h11,
    FUNCT_MFLO  = 6'h12,
    FUNCT_MTLO  = 6'h13,
    FUNCT_MULT  = 6'h18,
    FUNCT_MULTU = 6'h19,
    FUNCT_DIV   = 6'h1A,
    FUNCT_DIVU  = 6'h1B
  } funct_t;

  typedef enum logic [1:0] {
    MDU_IDLE,
    MDU_CALC,
    MDU_FIXUP
  } mdu_state_t;

  localparam int MDU_DEFAULT_WIDTH = 32;

  // True for the four operations that run through the bit-serial engine.
  function automatic logic isIterative(funct_t f);
    return (f == FUNCT_MULT) || (f == FUNCT_MULTU) ||
           (f == FUNCT_DIV)  || (f == FUNCT_DIVU);
  endfunction

  // True for the operations whose operands are two's-complement.
  function automatic logic isSignedOp(funct_t f);
    return (f == FUNCT_MULT) || (f == FUNCT_DIV);
  endfunction

  // True for the two divide flavours.
  function automatic logic isDivideOp(funct_t f);
    return (f == FUNCT_DIV) || (f == FUNCT_DIVU);
  endfunction

endpackage

// File: rtl/mul_div_unit.sv
// mul_div_unit
//   Multi-cycle multiply/divide unit that owns the HI/LO register pair.
//   MULT/MULTU/DIV/DIVU run one bit per cycle on magnitudes, with a final
//   sign fix-up; MTHI/MTLO write a register in a single cycle.
// Ports
//   clk     in   1        rising-edge clock
//   rst_n   in   1        asynchronous active-low reset
//   start   in   1        request, accepted only while busy=0
//   fncode  in   funct_t  operation select; unlisted codes are no-ops
//   a       in   WIDTH    rs operand (multiplicand / dividend / MTHI-MTLO data)
//   b       in   WIDTH    rt operand (multiplier / divisor)
//   busy    out  1        iterative operation in flight
//   done    out  1        one-cycle pulse, hi/lo hold the new result
//   hi      out  WIDTH    HI register (product high half / remainder)
//   lo      out  WIDTH    LO register (product low half / quotient)
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int WIDTH = MDU_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  funct_t           fncode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH);

  mdu_state_t             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [2*WIDTH-1:0]     acc_q, acc_d;
  logic [WIDTH-1:0]       opnd_q, opnd_d;
  logic                   isDiv_q, isDiv_d;
  logic                   resNeg_q, resNeg_d;
  logic                   remNeg_q, remNeg_d;
  logic [WIDTH-1:0]       hi_q, hi_d;
  logic [WIDTH-1:0]       lo_q, lo_d;
  logic                   done_q, done_d;

  logic                   aNeg, bNeg;
  logic [WIDTH-1:0]       aMag, bMag;
  logic [WIDTH:0]         mulSum;
  logic [WIDTH:0]         remShift;
  logic [WIDTH:0]         divDiff;
  logic [2*WIDTH-1:0]     prodFix;
  logic [WIDTH-1:0]       quoFix, remFix;

  // Next-state and datapath logic.
  // The accumulator is shared: for multiply its upper half collects partial
  // sums while the multiplier shifts out of the lower half; for divide the
  // upper half is the running remainder and quotient bits shift into the
  // lower half. Operands are reduced to magnitudes on accept, and the sign
  // flags restore the signs in FIXUP. A zero divisor naturally yields an
  // all-ones quotient and the dividend magnitude as remainder, so quotient
  // negation is suppressed for b=0 and the remainder sign fix turns |a| back
  // into a. The DIV overflow case (most-negative / -1) falls out of the same
  // arithmetic: |a| / 1 negated wraps back to a.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    isDiv_d  = isDiv_q;
    resNeg_d = resNeg_q;
    remNeg_d = remNeg_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;

    aNeg = isSignedOp(fncode) && a[WIDTH-1];
    bNeg = isSignedOp(fncode) && b[WIDTH-1];
    aMag = aNeg ? -a : a;
    bMag = bNeg ? -b : b;

    mulSum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    remShift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    divDiff  = remShift - {1'b0, opnd_q};

    prodFix = resNeg_q ? -acc_q : acc_q;
    quoFix  = resNeg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    remFix  = remNeg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

    case (state_q)
      MDU_IDLE: begin
        if (start) begin
          if (isIterative(fncode)) begin
            isDiv_d  = isDivideOp(fncode);
            opnd_d   = bMag;
            acc_d    = {{WIDTH{1'b0}}, aMag};
            resNeg_d = (aNeg ^ bNeg) && (b != '0);
            remNeg_d = aNeg;
            cnt_d    = CNT_W'(WIDTH - 1);
            state_d  = MDU_CALC;
          end else if (fncode == FUNCT_MTHI) begin
            hi_d   = a;
            done_d = 1'b1;
          end else if (fncode == FUNCT_MTLO) begin
            lo_d   = a;
            done_d = 1'b1;
          end
        end
      end
      MDU_CALC: begin
        if (isDiv_q) begin
          if (divDiff[WIDTH]) begin
            acc_d = {remShift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
          end else begin
            acc_d = {divDiff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
          end
        end else begin
          acc_d = {mulSum, acc_q[WIDTH-1:1]};
        end
        if (cnt_q == '0) begin
          state_d = MDU_FIXUP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      MDU_FIXUP: begin
        if (isDiv_q) begin
          hi_d = remFix;
          lo_d = quoFix;
        end else begin
          hi_d = prodFix[2*WIDTH-1:WIDTH];
          lo_d = prodFix[WIDTH-1:0];
        end
        done_d  = 1'b1;
        state_d = MDU_IDLE;
      end
      default: begin
        state_d = MDU_IDLE;
      end
    endcase
  end

  // State, counter and register update. Reset is asynchronous and clears
  // everything, discarding any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= MDU_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      isDiv_q  <= 1'b0;
      resNeg_q <= 1'b0;
      remNeg_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      isDiv_q  <= isDiv_d;
      resNeg_q <= resNeg_d;
      remNeg_q <= remNeg_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  assign busy = (state_q != MDU_IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit
//   Directed and random checks of mul_div_unit at WIDTH=32 and WIDTH=8
//   against an arithmetic reference model.
module tb_mul_div_unit;
  import mul_div_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start32, start8;
  funct_t      fn;
  logic [31:0] a32, b32, hi32, lo32;
  logic [7:0]  a8, b8, hi8, lo8;
  logic        busy32, busy8, done32, done8;

  int errors = 0;
  int checks = 0;
  logic [31:0] mHi [2];
  logic [31:0] mLo [2];

  always #5 clk = ~clk;

  mul_div_unit #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .start(start32), .fncode(fn),
    .a(a32), .b(b32), .busy(busy32), .done(done32), .hi(hi32), .lo(lo32)
  );

  mul_div_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .fncode(fn),
    .a(a8), .b(b8), .busy(busy8), .done(done8), .hi(hi8), .lo(lo8)
  );

  // Hard stop in case something hangs outside the bounded waits.
  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic int idx(int w);
    return (w == 32) ? 0 : 1;
  endfunction

  function automatic logic [31:0] obsHi(int w);
    return (w == 32) ? hi32 : {24'b0, hi8};
  endfunction

  function automatic logic [31:0] obsLo(int w);
    return (w == 32) ? lo32 : {24'b0, lo8};
  endfunction

  function automatic logic obsBusy(int w);
    return (w == 32) ? busy32 : busy8;
  endfunction

  function automatic logic obsDone(int w);
    return (w == 32) ? done32 : done8;
  endfunction

  // Reference behaviour computed with plain integer arithmetic: returns {hi,lo}.
  function automatic logic [63:0] refModel(int w, funct_t f, logic [31:0] av, logic [31:0] bv,
                                           logic [31:0] oldHi, logic [31:0] oldLo);
    longint unsigned mask, ua, ub, p, rh, rl;
    longint sa, sb, q, r;
    mask = (64'd1 << w) - 64'd1;
    ua = {32'b0, av} & mask;
    ub = {32'b0, bv} & mask;
    sa = ua[w-1] ? longint'(ua) - longint'(64'd1 << w) : longint'(ua);
    sb = ub[w-1] ? longint'(ub) - longint'(64'd1 << w) : longint'(ub);
    rh = {32'b0, oldHi};
    rl = {32'b0, oldLo};
    case (f)
      FUNCT_MULTU: begin
        p = ua * ub;
        rh = (p >> w) & mask;
        rl = p & mask;
      end
      FUNCT_MULT: begin
        p = longint'(sa * sb);
        rh = (p >> w) & mask;
        rl = p & mask;
      end
      FUNCT_DIVU: begin
        if (ub == 0) begin
          rh = ua;
          rl = mask;
        end else begin
          rl = ua / ub;
          rh = ua % ub;
        end
      end
      FUNCT_DIV: begin
        if (ub == 0) begin
          rh = ua;
          rl = mask;
        end else if (sa == -longint'(64'd1 << (w - 1)) && sb == -1) begin
          rh = 0;
          rl = ua;
        end else begin
          q = sa / sb;
          r = sa % sb;
          rh = longint'(r) & mask;
          rl = longint'(q) & mask;
        end
      end
      FUNCT_MTHI: rh = ua;
      FUNCT_MTLO: rl = ua;
      default: ;
    endcase
    return {rh[31:0], rl[31:0]};
  endfunction

  // One comparison: counts it and reports a failure with observed/expected.
  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic driveStart(input int w, input logic val);
    if (w == 32) start32 = val;
    else start8 = val;
  endtask

  // Presents a request and returns just after the accepting rising edge.
  task automatic launch(input int w, input funct_t f, input logic [31:0] av, input logic [31:0] bv,
                        input bit immediate);
    if (!immediate) @(negedge clk);
    fn = f;
    if (w == 32) begin
      a32 = av;
      b32 = bv;
    end else begin
      a8 = av[7:0];
      b8 = bv[7:0];
    end
    driveStart(w, 1'b1);
    @(posedge clk);
  endtask

  // Issues one operation, follows it to completion and checks timing,
  // busy, hold-until-fixup and the final hi/lo against the reference model.
  // Returns at the falling edge where done was seen (or the budget ran out).
  task automatic applyStimulus(input int w, input funct_t f, input logic [31:0] av,
                               input logic [31:0] bv, input bit immediate);
    int k, cyc, budget;
    bit iter, mt, seen;
    logic [63:0] expVal, oldVal;
    k      = idx(w);
    iter   = (f inside {FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU});
    mt     = (f inside {FUNCT_MTHI, FUNCT_MTLO});
    oldVal = {mHi[k], mLo[k]};
    expVal = refModel(w, f, av, bv, mHi[k], mLo[k]);
    budget = iter ? w + 4 : 4;
    launch(w, f, av, bv, immediate);
    cyc  = 0;
    seen = 0;
    while (1) begin
      @(negedge clk);
      if (cyc == 0) begin
        driveStart(w, 1'b0);
        checkOutput("busy_after_accept", {63'b0, obsBusy(w)}, {63'b0, iter});
      end
      if (iter && cyc == w && !obsDone(w))
        checkOutput("hold_until_fixup", {obsHi(w), obsLo(w)}, oldVal);
      if (obsDone(w)) begin
        seen = 1;
        break;
      end
      if (cyc >= budget) break;
      @(posedge clk);
      cyc++;
    end
    if (iter || mt) begin
      checkOutput("done_latency", seen ? 64'(cyc) : 64'hFFFF, iter ? 64'(w + 1) : 64'd0);
      checkOutput("busy_at_done", {63'b0, obsBusy(w)}, 64'd0);
    end else begin
      checkOutput("no_done_unlisted", {63'b0, seen}, 64'd0);
    end
    checkOutput("hilo", {obsHi(w), obsLo(w)}, expVal);
    mHi[k] = expVal[63:32];
    mLo[k] = expVal[31:0];
  endtask

  function automatic logic [31:0] pickOperand(int w);
    logic [31:0] mask;
    mask = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_00FF;
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return mask;
      3: return 32'd1 << (w - 1);
      default: return $urandom() & mask;
    endcase
  endfunction

  function automatic funct_t pickFunct();
    case ($urandom_range(0, 10))
      0, 1: return FUNCT_MULT;
      2, 3: return FUNCT_MULTU;
      4, 5: return FUNCT_DIV;
      6, 7: return FUNCT_DIVU;
      8: return FUNCT_MTHI;
      9: return FUNCT_MTLO;
      default: return funct_t'(6'h20);
    endcase
  endfunction

  // Directed steps followed by random traffic on both widths.
  initial begin
    int cyc, doneCount, doneCyc;
    rst_n   = 1'b0;
    start32 = 1'b0;
    start8  = 1'b0;
    fn      = FUNCT_MULTU;
    a32 = '0; b32 = '0; a8 = '0; b8 = '0;
    for (int i = 0; i < 2; i++) begin
      mHi[i] = '0;
      mLo[i] = '0;
    end

    #12;
    checkOutput("reset_hi32", {32'b0, hi32}, 64'd0);
    checkOutput("reset_lo32", {32'b0, lo32}, 64'd0);
    checkOutput("reset_busy_done32", {62'b0, busy32, done32}, 64'd0);
    checkOutput("reset_all8", {46'b0, busy8, done8, hi8, lo8}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(32, FUNCT_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    checkOutput("multu_max", {hi32, lo32}, 64'hFFFF_FFFE_0000_0001);
    @(posedge clk);
    @(negedge clk);
    checkOutput("done_one_cycle", {63'b0, done32}, 64'd0);

    applyStimulus(32, FUNCT_MULT, 32'hFFFF_FFFD, 32'd5, 0);
    checkOutput("mult_neg", {hi32, lo32}, 64'hFFFF_FFFF_FFFF_FFF1);
    applyStimulus(32, FUNCT_DIV, 32'hFFFF_FFF9, 32'd2, 0);
    checkOutput("div_neg", {hi32, lo32}, 64'hFFFF_FFFF_FFFF_FFFD);
    applyStimulus(32, FUNCT_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    checkOutput("div_overflow", {hi32, lo32}, 64'h0000_0000_8000_0000);
    applyStimulus(32, FUNCT_DIVU, 32'd7, 32'd0, 0);
    checkOutput("divu_by_zero", {hi32, lo32}, 64'h0000_0007_FFFF_FFFF);
    applyStimulus(32, FUNCT_DIV, 32'hFFFF_FFF9, 32'd0, 0);
    checkOutput("div_by_zero_neg", {hi32, lo32}, 64'hFFFF_FFF9_FFFF_FFFF);
    applyStimulus(32, FUNCT_MTHI, 32'h0000_1234, 32'd0, 0);
    checkOutput("mthi_hi", {32'b0, hi32}, 64'h1234);
    applyStimulus(32, FUNCT_MTLO, 32'h0000_5678, 32'd0, 0);
    checkOutput("mtlo_lo", {32'b0, lo32}, 64'h5678);
    applyStimulus(32, funct_t'(6'h20), 32'hDEAD, 32'hBEEF, 0);
    applyStimulus(32, FUNCT_MFHI, 32'hDEAD, 32'hBEEF, 0);

    applyStimulus(32, FUNCT_DIVU, 32'd9, 32'd2, 0);
    applyStimulus(32, FUNCT_MULTU, 32'd6, 32'd7, 1);
    checkOutput("back_to_back", {hi32, lo32}, 64'd42);

    launch(32, FUNCT_DIVU, 32'd100, 32'd7, 0);
    cyc = 0;
    doneCount = 0;
    doneCyc = -1;
    while (cyc <= 45) begin
      @(negedge clk);
      if (cyc == 0) start32 = 1'b0;
      if (cyc == 5) begin
        fn = FUNCT_MULTU;
        a32 = 32'd3;
        b32 = 32'd3;
        start32 = 1'b1;
      end
      if (cyc == 6) start32 = 1'b0;
      if (done32) begin
        doneCount++;
        doneCyc = cyc;
      end
      @(posedge clk);
      cyc++;
    end
    @(negedge clk);
    checkOutput("busy_start_single_done", 64'(doneCount), 64'd1);
    checkOutput("busy_start_latency", 64'(doneCyc), 64'd33);
    checkOutput("busy_start_result", {hi32, lo32}, {32'd2, 32'd14});
    mHi[0] = 32'd2;
    mLo[0] = 32'd14;

    applyStimulus(32, FUNCT_MTHI, 32'h0000_AAAA, 32'd0, 0);
    applyStimulus(32, FUNCT_MTLO, 32'h0000_5555, 32'd0, 0);
    launch(32, FUNCT_MULT, 32'd123, 32'd456, 0);
    @(negedge clk);
    start32 = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset_busy_done", {62'b0, busy32, done32}, 64'd0);
    checkOutput("async_reset_hilo", {hi32, lo32}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      mHi[i] = '0;
      mLo[i] = '0;
    end

    applyStimulus(8, FUNCT_DIV, 32'h80, 32'hFF, 0);
    checkOutput("div8_overflow", {hi8, lo8}, 16'h0080);
    applyStimulus(8, FUNCT_MULT, 32'h80, 32'h80, 0);
    checkOutput("mult8_min", {hi8, lo8}, 16'h4000);

    for (int i = 0; i < 300; i++)
      applyStimulus(32, pickFunct(), pickOperand(32), pickOperand(32), 0);
    for (int i = 0; i < 1200; i++)
      applyStimulus(8, pickFunct(), pickOperand(8), pickOperand(8), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
